// File: rtl/shift_rom_sequencer.sv
// shift_rom_sequencer: block-RAM word buffer filled by a LOAD stream and replayed by a PLAY stream.
// Ports: clock/reset_n (async active-low); cfg_length/cfg_repeat configuration;
// load_start/load_valid/load_data/load_ready write stream; play_start/abort control;
// out_valid/out_ready/out_data/out_last read stream; busy/done/state status.
module shift_rom_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH:0]   cfg_length,
    input  logic [7:0]            cfg_repeat,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  play_start,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   len_c;
    logic [7:0]            rep;
    logic [7:0]            pass;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] bram_q;
    logic                  bram_last;
    logic                  bram_v;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_v;
    logic                  o_last;
    logic                  o_v;
    logic [1:0]            cnt;
    logic                  acc;
    logic                  take;
    logic                  iss;
    logic                  we;
    logic                  wr_last;
    logic                  rd_last;
    logic                  finish;

    assign len_c      = cfg_length > DEPTH ? DEPTH : cfg_length;
    assign load_ready = state == ST_LOAD;
    assign busy       = state != ST_IDLE;
    assign out_valid  = o_v;
    assign out_last   = o_v & o_last;
    assign acc        = o_v & out_ready;
    assign take       = !o_v | out_ready;
    assign we         = load_ready & load_valid & !abort;
    assign wr_last    = {1'b0, wr_addr} == len - (ADDR_WIDTH+1)'(1);
    assign rd_last    = {1'b0, rd_addr} == len - (ADDR_WIDTH+1)'(1);
    // Words held by BRAM output, output and skid registers; a read is issued only
    // when, after this cycle's acceptance, the new word is guaranteed a slot.
    assign cnt        = {1'b0, o_v} + {1'b0, s_v} + {1'b0, bram_v};
    assign iss        = state == ST_PLAY && (cnt - {1'b0, acc}) < 2'd2;
    assign finish     = acc & o_last & rep != 8'd0 & (pass + 8'd1 == rep);

    always_ff @(posedge clock) begin
        if (we) mem[wr_addr] <= load_data;
        if (iss) begin
            bram_q    <= mem[rd_addr];
            bram_last <= rd_last;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            len      <= '0;
            rep      <= '0;
            pass     <= '0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            bram_v   <= 1'b0;
            s_data   <= '0;
            s_last   <= 1'b0;
            s_v      <= 1'b0;
            out_data <= '0;
            o_last   <= 1'b0;
            o_v      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            bram_v <= iss;
            if (iss) rd_addr <= rd_last ? '0 : rd_addr + ADDR_WIDTH'(1);
            if (take) begin
                out_data <= s_v ? s_data : bram_q;
                o_last   <= s_v ? s_last : bram_last;
                o_v      <= s_v | bram_v;
                s_data   <= bram_q;
                s_last   <= bram_last;
                s_v      <= s_v & bram_v;
            end else if (bram_v) begin
                s_data <= bram_q;
                s_last <= bram_last;
                s_v    <= 1'b1;
            end
            if (acc && o_last) pass <= pass + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (!abort && cfg_length != '0) begin
                        if (load_start) begin
                            state   <= ST_LOAD;
                            len     <= len_c;
                            wr_addr <= '0;
                        end else if (play_start) begin
                            state   <= ST_PLAY;
                            len     <= len_c;
                            rep     <= cfg_repeat;
                            rd_addr <= '0;
                            pass    <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (we) wr_addr <= wr_addr + ADDR_WIDTH'(1);
                    if (abort || (we && wr_last)) begin
                        state <= ST_IDLE;
                        done  <= !abort;
                    end
                end
                ST_PLAY: begin
                    // Completion or abort flushes all prefetched words.
                    if (abort || finish) begin
                        state  <= ST_IDLE;
                        done   <= !abort;
                        o_v    <= 1'b0;
                        s_v    <= 1'b0;
                        bram_v <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
